// File: rtl/pwm_ramp_ctrl.sv
// Duty-ramp sequencer for a pwm instance: one-shot fades or triangle loops,
// configured through shadow registers loaded by a valid/ready handshake.
module pwm_ramp_ctrl #(
    parameter int unsigned N  = 32,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [N-1:0]  cfg_period,
    input  logic [N-1:0]  cfg_duty_start,
    input  logic [N-1:0]  cfg_duty_end,
    input  logic [N-1:0]  cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          stop,
    output logic [N-1:0]  period,
    output logic [N-1:0]  duty,
    output logic          pwm_en,
    output logic          busy,
    output logic          done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;

    logic [N-1:0]  sh_period;
    logic [N-1:0]  sh_start;
    logic [N-1:0]  sh_end;
    logic [N-1:0]  sh_step;
    logic [DW-1:0] sh_dwell;
    logic          sh_loop;

    logic [DW-1:0] dwell_cnt;
    logic [N-1:0]  target;
    logic [N-1:0]  origin;
    logic          dir_up;

    logic          cfg_acc;
    logic [N-1:0]  eff_period;
    logic [N-1:0]  eff_start;
    logic [N-1:0]  eff_end;
    logic [DW-1:0] eff_dwell;
    logic [N-1:0]  step_eff;

    // One level step toward tgt, saturating at tgt; N+1 bits catch carry/borrow.
    function automatic logic [N-1:0] next_level(
        input logic [N-1:0] cur,
        input logic [N-1:0] tgt,
        input logic [N-1:0] stp,
        input logic         up
    );
        logic [N:0] sum;
        logic [N:0] dif;
        logic [N-1:0] res;
        sum = {1'b0, cur} + {1'b0, stp};
        dif = {1'b0, cur} - {1'b0, stp};
        if (up) begin
            res = (sum > {1'b0, tgt}) ? tgt : sum[N-1:0];
        end else begin
            res = (dif[N] || (dif[N-1:0] < tgt)) ? tgt : dif[N-1:0];
        end
        return res;
    endfunction

    assign cfg_ready = (state == IDLE);
    assign cfg_acc   = cfg_valid && cfg_ready;

    // A config beat accepted together with start feeds the run directly.
    assign eff_period = cfg_acc ? cfg_period     : sh_period;
    assign eff_start  = cfg_acc ? cfg_duty_start : sh_start;
    assign eff_end    = cfg_acc ? cfg_duty_end   : sh_end;
    assign eff_dwell  = cfg_acc ? cfg_dwell      : sh_dwell;
    assign step_eff   = (sh_step == '0) ? N'(1) : sh_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh_period <= '0;
            sh_start  <= '0;
            sh_end    <= '0;
            sh_step   <= '0;
            sh_dwell  <= '0;
            sh_loop   <= 1'b0;
            dwell_cnt <= '0;
            target    <= '0;
            origin    <= '0;
            dir_up    <= 1'b0;
            period    <= '0;
            duty      <= '0;
            pwm_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_acc) begin
                        sh_period <= cfg_period;
                        sh_start  <= cfg_duty_start;
                        sh_end    <= cfg_duty_end;
                        sh_step   <= cfg_step;
                        sh_dwell  <= cfg_dwell;
                        sh_loop   <= cfg_loop;
                    end
                    if (stop) begin
                        duty   <= '0;
                        pwm_en <= 1'b0;
                    end else if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        pwm_en    <= 1'b1;
                        duty      <= eff_start;
                        period    <= eff_period;
                        dwell_cnt <= eff_dwell;
                        target    <= eff_end;
                        origin    <= eff_start;
                        dir_up    <= (eff_end >= eff_start);
                    end
                end
                RUN: begin
                    if (stop) begin
                        state  <= IDLE;
                        duty   <= '0;
                        pwm_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DW'(1);
                    end else if (duty != target) begin
                        duty      <= next_level(duty, target, step_eff, dir_up);
                        dwell_cnt <= sh_dwell;
                    end else if (!sh_loop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Turnaround: the endpoint level is not held twice.
                        target    <= origin;
                        origin    <= target;
                        dir_up    <= !dir_up;
                        duty      <= next_level(duty, origin, step_eff, !dir_up);
                        dwell_cnt <= sh_dwell;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: per-cycle expectations are queued with a
// cycle stamp when a run is launched and compared as the DUT reaches them.
module tb_pwm_ramp_ctrl;
    localparam int unsigned N  = 32;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [N-1:0]  cfg_period = '0;
    logic [N-1:0]  cfg_duty_start = '0;
    logic [N-1:0]  cfg_duty_end = '0;
    logic [N-1:0]  cfg_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          cfg_loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [N-1:0]  period;
    logic [N-1:0]  duty;
    logic          pwm_en;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.N(N), .DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_duty_start (cfg_duty_start),
        .cfg_duty_end   (cfg_duty_end),
        .cfg_step       (cfg_step),
        .cfg_dwell      (cfg_dwell),
        .cfg_loop       (cfg_loop),
        .start          (start),
        .stop           (stop),
        .period         (period),
        .duty           (duty),
        .pwm_en         (pwm_en),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] duty;
        logic [N-1:0] period;
        logic         en;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t        sb_q[$];
    string       tag_q[$];
    int unsigned lv[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          b;
    exp_t        m_e;
    string       m_t;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard consumer: compare each queued expectation in its own cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            m_e = sb_q.pop_front();
            m_t = tag_q.pop_front();
            checks++;
            errors++;
            $error("FAIL %s: observed no sample at cycle %0d expected duty %0d", m_t, m_e.cyc, m_e.duty);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            m_e = sb_q.pop_front();
            m_t = tag_q.pop_front();
            checks++;
            assert ({duty, period, pwm_en, busy, done} === {m_e.duty, m_e.period, m_e.en, m_e.busy, m_e.done})
            else begin
                errors++;
                $error("FAIL %s@%0d: observed duty=%0d period=%0d en=%b busy=%b done=%b expected duty=%0d period=%0d en=%b busy=%b done=%b",
                       m_t, cyc, duty, period, pwm_en, busy, done,
                       m_e.duty, m_e.period, m_e.en, m_e.busy, m_e.done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int at, input int unsigned d,
                            input int unsigned p, input logic en, input logic bz, input logic dn);
        exp_t e;
        e.cyc = at;
        e.duty = N'(d);
        e.period = N'(p);
        e.en = en;
        e.busy = bz;
        e.done = dn;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic push_ramp(input string tag, input int base, input int unsigned levels[$],
                             input int unsigned p);
        foreach (levels[i]) push_exp(tag, base + i + 1, levels[i], p, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic cfg_write(input int unsigned p, input int unsigned s, input int unsigned e,
                             input int unsigned st, input int unsigned dw, input logic lp);
        cfg_period     = N'(p);
        cfg_duty_start = N'(s);
        cfg_duty_end   = N'(e);
        cfg_step       = N'(st);
        cfg_dwell      = DW'(dw);
        cfg_loop       = lp;
        cfg_valid      = 1'b1;
        tick();
        cfg_valid      = 1'b0;
    endtask

    task automatic kick(output int base);
        base = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        assert (sb_q.size() == 0)
        else begin
            errors++;
            $error("FAIL %s drain: observed %0d pending expected 0", tag, sb_q.size());
            sb_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        #12;
        chk("rst duty", duty, 0);
        chk("rst period", period, 0);
        chk("rst pwm_en", N'(pwm_en), 0);
        chk("rst busy", N'(busy), 0);
        chk("rst done", N'(done), 0);
        chk("rst cfg_ready", N'(cfg_ready), 1);
        #6 rst_n = 1'b1;
        tick();

        // One-shot up with clamp at the end level
        cfg_write(1000, 0, 10, 4, 1, 1'b0);
        kick(b);
        lv = '{0, 0, 4, 4, 8, 8, 10, 10};
        push_ramp("up", b, lv, 1000);
        push_exp("up_done", b + 9, 10, 1000, 1'b1, 1'b0, 1'b1);
        push_exp("up_hold", b + 10, 10, 1000, 1'b1, 1'b0, 1'b0);
        drain("up");

        // One-shot down with saturation at 0
        cfg_write(500, 100, 0, 30, 0, 1'b0);
        kick(b);
        lv = '{100, 70, 40, 10, 0};
        push_ramp("down", b, lv, 500);
        push_exp("down_done", b + 6, 0, 500, 1'b1, 1'b0, 1'b1);
        drain("down");

        // Triangle loop; config offered during the run must be refused
        cfg_write(200, 0, 2, 1, 0, 1'b1);
        kick(b);
        lv = '{0, 1, 2, 1, 0, 1, 2};
        push_ramp("loop", b, lv, 200);
        push_exp("loop_stop", b + 8, 0, 200, 1'b0, 1'b0, 1'b0);
        push_exp("loop_idle", b + 9, 0, 200, 1'b0, 1'b0, 1'b0);
        cfg_duty_start = N'(50);
        cfg_period = N'(999);
        cfg_valid = 1'b1;
        tick();
        chk("run cfg_ready", N'(cfg_ready), 0);
        repeat (4) tick();
        cfg_valid = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain("loop");
        chk("idle cfg_ready", N'(cfg_ready), 1);

        // Rerun: shadow config unchanged by the refused beat
        kick(b);
        lv = '{0, 1, 2};
        push_ramp("oldcfg", b, lv, 200);
        push_exp("oldcfg_stop", b + 4, 0, 200, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain("oldcfg");

        // Config accepted in the same cycle as start
        cfg_period = N'(300);
        cfg_duty_start = N'(20);
        cfg_duty_end = N'(22);
        cfg_step = N'(1);
        cfg_dwell = DW'(0);
        cfg_loop = 1'b0;
        cfg_valid = 1'b1;
        kick(b);
        cfg_valid = 1'b0;
        lv = '{20, 21, 22};
        push_ramp("bypass", b, lv, 300);
        push_exp("bypass_done", b + 4, 22, 300, 1'b1, 1'b0, 1'b1);
        drain("bypass");

        // start and stop together: stays idle and gates the output
        b = cyc;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        push_exp("startstop", b + 1, 0, 300, 1'b0, 1'b0, 1'b0);
        push_exp("startstop2", b + 2, 0, 300, 1'b0, 1'b0, 1'b0);
        drain("startstop");
        chk("startstop cfg_ready", N'(cfg_ready), 1);

        // step of 0 behaves as 1
        cfg_write(100, 5, 7, 0, 0, 1'b0);
        kick(b);
        lv = '{5, 6, 7};
        push_ramp("step0", b, lv, 100);
        push_exp("step0_done", b + 4, 7, 100, 1'b1, 1'b0, 1'b1);
        drain("step0");

        // start == end one-shot just dwells
        cfg_write(100, 0, 0, 3, 3, 1'b0);
        kick(b);
        lv = '{0, 0, 0, 0};
        push_ramp("flat", b, lv, 100);
        push_exp("flat_done", b + 5, 0, 100, 1'b1, 1'b0, 1'b1);
        drain("flat");

        // Asynchronous reset in the middle of a ramp
        cfg_write(400, 0, 100, 20, 3, 1'b0);
        kick(b);
        lv = '{0, 0, 0, 0, 20, 20, 20, 20, 40, 40};
        push_ramp("prerst", b, lv, 400);
        repeat (9) tick();
        @(negedge clk);
        #1;
        chk("prerst duty", duty, 40);
        rst_n = 1'b0;
        #1;
        chk("arst duty", duty, 0);
        chk("arst period", period, 0);
        chk("arst pwm_en", N'(pwm_en), 0);
        chk("arst busy", N'(busy), 0);
        chk("arst done", N'(done), 0);
        chk("arst cfg_ready", N'(cfg_ready), 1);
        #2 rst_n = 1'b1;
        tick();
        cfg_duty_start = N'(77);
        cfg_period = N'(55);
        kick(b);
        lv = '{0};
        push_ramp("shadow0", b, lv, 0);
        push_exp("shadow0_done", b + 2, 0, 0, 1'b1, 1'b0, 1'b1);
        drain("shadow0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
